// File: rtl/dot_product_stream.sv
// Streaming dot-product engine.
//
// Consumes LANES operand pairs per accepted beat for a run-time number of beats,
// multiply-accumulates them through a two-stage pipeline and returns the
// ACC_W-bit result over a valid/ready handshake.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        begin an operation (sampled only while idle)
//   len          beat count, latched on start (0 gives an immediate zero result)
//   signed_mode  1 = two's-complement operands, latched on start
//   sat_mode     1 = saturate accumulator, 0 = wrap, latched on start
//   busy         high whenever an operation is in progress
//   in_valid/in_ready/in_a/in_b  operand stream, lane i at [i*DATA_W +: DATA_W]
//   res_valid/res_ready/result   result handshake
//   overflow     sticky: some accumulation left the ACC_W range this operation
module dot_product_stream #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 2,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned ACC_W  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    signed_mode,
  input  logic                    sat_mode,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_W-1:0]        result,
  output logic                    overflow
);

  localparam int unsigned PROD_W = 2 * DATA_W + 1;
  localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);
  // Wide enough that acc + lane sum can never wrap before the range check.
  localparam int unsigned EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic signed [EXT_W-1:0]  ext_t;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StResult} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic             signed_q;
  logic             sat_q;
  logic             s1_valid_q;
  sum_t             s1_sum_q;
  logic             s2_valid_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [ACC_W-1:0] result_q;
  logic             busy_q;
  logic             in_ready_q;
  logic             res_valid_q;

  logic             accept;
  sum_t             lane_sum;
  ext_t             acc_x;
  ext_t             sum_x;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_nxt;

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;

  assign accept = in_valid && in_ready_q;

  // Operands extended to PROD_W bits; the exact product always fits there.
  function automatic prod_t lane_prod(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b,
                                      input logic              sgn);
    prod_t ax;
    prod_t bx;
    ax = {{(DATA_W + 1){sgn & a[DATA_W-1]}}, a};
    bx = {{(DATA_W + 1){sgn & b[DATA_W-1]}}, b};
    return ax * bx;
  endfunction

  // Stage 1: lane products and their sum.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + sum_t'(lane_prod(in_a[i*DATA_W +: DATA_W],
                                             in_b[i*DATA_W +: DATA_W], signed_q));
    end
  end

  // Stage 2: accumulate with range check and optional clamp.
  always_comb begin
    acc_x = signed_q ? ext_t'(signed'(acc_q)) : ext_t'(acc_q);
    sum_x = acc_x + ext_t'(s1_sum_q);
    if (signed_q) begin
      add_ovf = !((&sum_x[EXT_W-1:ACC_W-1]) || !(|sum_x[EXT_W-1:ACC_W-1]));
    end else begin
      add_ovf = |sum_x[EXT_W-1:ACC_W];
    end
    acc_nxt = sum_x[ACC_W-1:0];
    if (add_ovf && sat_q) begin
      if (signed_q) begin
        acc_nxt = sum_x[EXT_W-1] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
      end else begin
        acc_nxt = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      sat_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s2_valid_q  <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_sum_q <= lane_sum;
      end
      // Marks the cycle in which the last stage-2 write lands.
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        acc_q <= acc_nxt;
        if (add_ovf) begin
          ovf_q <= 1'b1;
        end
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q    <= len;
            signed_q <= signed_mode;
            sat_q    <= sat_mode;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            if (len == '0) begin
              state_q     <= StResult;
              result_q    <= '0;
              res_valid_q <= 1'b1;
            end else begin
              state_q    <= StRun;
              in_ready_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (accept) begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q    <= StDrain;
              in_ready_q <= 1'b0;
            end
          end
        end
        StDrain: begin
          if (!s1_valid_q && !s2_valid_q) begin
            state_q     <= StResult;
            result_q    <= acc_q;
            res_valid_q <= 1'b1;
          end
        end
        StResult: begin
          if (res_ready) begin
            state_q     <= StIdle;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
